// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder:
// RV32I load/store width codes and MMIO register offsets.
package dmem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MMIO_CYCLE  = 4'h0;
    localparam logic [3:0] MMIO_STORES = 4'h4;
    localparam logic [3:0] MMIO_TOHOST = 4'h8;
    localparam logic [3:0] MMIO_STATUS = 4'hC;

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage data bus between the pipeline (master)
// and the data-memory responder (slave).
interface dmem_responder_if #(
    parameter int AW = 9,
    parameter int DW = 32
);
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [2:0]    func3;
    logic [DW-1:0] rd_data;

    modport master (
        output wr, rd, addr, wr_data, func3,
        input  rd_data
    );

    modport slave (
        input  wr, rd, addr, wr_data, func3,
        output rd_data
    );
endinterface

// File: rtl/dmem_responder_lsu_align.sv
// Byte-lane steering for RV32I sub-word loads/stores,
// plus misalignment and illegal width-code detection.
module lsu_align
    import dmem_responder_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              is_store,
    input  logic              is_load,
    input  logic [1:0]        offset,
    input  logic [2:0]        func3,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] ram_word,
    output logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0] st_lanes,
    output logic [DATA_W-1:0] ld_data,
    output logic              misalign,
    output logic              illegal
);
    localparam int NB = DATA_W / 8;

    localparam logic [NB-1:0] BE_B = {{(NB-1){1'b0}}, 1'b1};
    localparam logic [NB-1:0] BE_H = {{(NB-2){1'b0}}, 2'b11};

    logic [DATA_W-1:0] shifted;
    logic [7:0]        lb;
    logic [15:0]       lh;

    assign shifted = ram_word >> {offset, 3'b000};
    assign lb      = shifted[7:0];
    assign lh      = shifted[15:0];

    // Decode width code into lane enables, load extension and error flags.
    always_comb begin
        byte_en  = '0;
        st_lanes = '0;
        ld_data  = '0;
        misalign = 1'b0;
        illegal  = 1'b0;
        if (is_store) begin
            unique case (func3)
                F3_B: begin
                    byte_en  = BE_B << offset;
                    st_lanes = {NB{wr_data[7:0]}};
                end
                F3_H: begin
                    byte_en  = BE_H << offset;
                    st_lanes = {(NB/2){wr_data[15:0]}};
                    misalign = offset[0];
                end
                F3_W: begin
                    byte_en  = '1;
                    st_lanes = wr_data;
                    misalign = |offset;
                end
                default: illegal = 1'b1;
            endcase
        end
        if (is_load) begin
            unique case (func3)
                F3_B:  ld_data = {{(DATA_W-8){lb[7]}}, lb};
                F3_BU: ld_data = {{(DATA_W-8){1'b0}}, lb};
                F3_H: begin
                    ld_data  = {{(DATA_W-16){lh[15]}}, lh};
                    misalign = offset[0];
                end
                F3_HU: begin
                    ld_data  = {{(DATA_W-16){1'b0}}, lh};
                    misalign = offset[0];
                end
                F3_W: begin
                    ld_data  = ram_word;
                    misalign = |offset;
                end
                default: illegal = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-addressable RAM with RV32I
// sub-word access and a 16-byte MMIO window.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter logic [DM_ADDRESS-1:0] MMIO_BASE = 9'h1F0
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus,
    output logic              err,
    output logic              done,
    output logic [DATA_W-1:0] tohost
);
    localparam int WORDS = 2 ** (DM_ADDRESS - 2);
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] ram [WORDS] = '{default: '0};

    logic [DATA_W-1:0]   cycle;
    logic [DATA_W-1:0]   stores;
    logic [DM_ADDRESS-3:0] widx;
    logic [3:0]          off;
    logic                in_mmio;
    logic                req;
    logic                ro_store;
    logic                acc_err;
    logic                ram_we;
    logic                th_we;
    logic [NB-1:0]       byte_en;
    logic [DATA_W-1:0]   st_lanes;
    logic [DATA_W-1:0]   ld_data;
    logic                misalign;
    logic                illegal;
    logic [DATA_W-1:0]   mmio_rdata;

    assign widx    = bus.addr[DM_ADDRESS-1:2];
    assign off     = bus.addr[3:0];
    assign in_mmio = bus.addr[DM_ADDRESS-1:4]
                  == MMIO_BASE[DM_ADDRESS-1:4];
    assign req     = bus.wr | bus.rd;

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .is_store (bus.wr),
        .is_load  (bus.rd),
        .offset   (bus.addr[1:0]),
        .func3    (bus.func3),
        .wr_data  (bus.wr_data),
        .ram_word (ram[widx]),
        .byte_en  (byte_en),
        .st_lanes (st_lanes),
        .ld_data  (ld_data),
        .misalign (misalign),
        .illegal  (illegal)
    );

    assign ro_store = bus.wr && in_mmio && off != MMIO_TOHOST;
    assign acc_err  = req && ((bus.wr && bus.rd) || misalign
                   || illegal || ro_store
                   || (in_mmio && bus.func3 != F3_W));
    // Only TOHOST survives acc_err as an MMIO store target.
    assign ram_we   = bus.wr && !acc_err && !in_mmio;
    assign th_we    = bus.wr && !acc_err && in_mmio;

    // MMIO register read mux (pre-update values).
    always_comb begin
        mmio_rdata = '0;
        unique case (off)
            MMIO_CYCLE:  mmio_rdata = cycle;
            MMIO_STORES: mmio_rdata = stores;
            MMIO_TOHOST: mmio_rdata = tohost;
            MMIO_STATUS: mmio_rdata = {{(DATA_W-2){1'b0}}, done, err};
            default:     mmio_rdata = '0;
        endcase
    end

    // Same-cycle load result; zero on no load or on any error.
    always_comb begin
        bus.rd_data = '0;
        if (bus.rd && !acc_err)
            bus.rd_data = in_mmio ? mmio_rdata : ld_data;
    end

    // RAM byte-lane write; reset blocks the write but never clears RAM.
    always_ff @(posedge clk) begin
        if (!reset && ram_we) begin
            for (int i = 0; i < NB; i++)
                if (byte_en[i])
                    ram[widx][8*i +: 8] <= st_lanes[8*i +: 8];
        end
    end

    // MMIO registers, sticky error and done flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle  <= '0;
            stores <= '0;
            tohost <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            cycle <= cycle + 1'b1;
            if (ram_we)
                stores <= stores + 1'b1;
            if (th_we) begin
                tohost <= bus.wr_data;
                done   <= 1'b1;
            end
            if (acc_err)
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios
// plus random traffic against a byte-array reference model.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        err;
    logic        done;
    logic [31:0] tohost;

    dmem_responder_if #(.AW(9), .DW(32)) bus ();

    dmem_responder dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .err    (err),
        .done   (done),
        .tohost (tohost)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0]  m_ram [512];
    logic [31:0] m_cycle  = 0;
    logic [31:0] m_stores = 0;
    logic        m_err    = 0;
    logic        m_done   = 0;
    logic [31:0] m_tohost = 0;

    localparam logic [8:0] MB = 9'h1F0;

    function automatic int m_size(logic [2:0] f);
        if (f[1:0] == 2'd0) return 1;
        if (f[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit m_mmio(logic [8:0] a);
        return a >= MB;
    endfunction

    function automatic bit m_bad(logic w, logic r,
                                 logic [8:0] a, logic [2:0] f);
        int sz;
        if (!w && !r) return 0;
        if (w && r) return 1;
        if (r && !(f == 0 || f == 1 || f == 2 || f == 4 || f == 5))
            return 1;
        if (w && f > 3'd2) return 1;
        sz = m_size(f);
        if ((int'(a) % sz) != 0) return 1;
        if (m_mmio(a) && sz != 4) return 1;
        if (w && m_mmio(a) && (int'(a) - int'(MB)) != 8) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] m_read(logic w, logic r,
                                           logic [8:0] a, logic [2:0] f);
        logic [31:0] v;
        int n;
        if (!r || m_bad(w, r, a, f)) return 0;
        if (m_mmio(a)) begin
            case (int'(a) - int'(MB))
                0:  return m_cycle;
                4:  return m_stores;
                8:  return m_tohost;
                12: return {30'd0, m_done, m_err};
                default: return 0;
            endcase
        end
        n = m_size(f);
        v = 0;
        for (int k = 0; k < n; k++)
            v = v | (32'(m_ram[int'(a) + k]) << (8 * k));
        if (!f[2] && n < 4 && v[8*n-1])
            v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic model_reset();
        m_cycle  = 0;
        m_stores = 0;
        m_err    = 0;
        m_done   = 0;
        m_tohost = 0;
    endtask

    task automatic do_op(input logic rst, input logic w, input logic r,
                         input logic [8:0] a, input logic [31:0] d,
                         input logic [2:0] f, output logic [31:0] rdata);
        bit b;
        @(negedge clk);
        reset       = rst;
        bus.wr      = w;
        bus.rd      = r;
        bus.addr    = a;
        bus.wr_data = d;
        bus.func3   = f;
        #1;
        rdata = bus.rd_data;
        b = m_bad(w, r, a, f);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_cycle = m_cycle + 1;
            if (b) begin
                m_err = 1;
            end else if (w) begin
                if (m_mmio(a)) begin
                    m_tohost = d;
                    m_done   = 1;
                end else begin
                    for (int k = 0; k < m_size(f); k++)
                        m_ram[int'(a) + k] = d[8*k +: 8];
                    m_stores = m_stores + 1;
                end
            end
        end
        #1;
        reset  = 1'b0;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset  = 1'b1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        @(posedge clk);
        model_reset();
        #1 reset = 1'b0;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        reset  = 1'b0;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        repeat (n) begin
            @(posedge clk);
            m_cycle = m_cycle + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        apply_reset();
        n_total++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL reset_err: got %b want 0", err);
        end
        n_total++;
        if (done !== 1'b0) begin
            n_bad++; $display("FAIL reset_done: got %b want 0", done);
        end
        n_total++;
        if (tohost !== 32'd0) begin
            n_bad++; $display("FAIL reset_tohost: got %h want 0", tohost);
        end
        do_op(0, 0, 1, MB + 9'h0, 0, 3'b010, r);
        n_total++;
        if (r !== 32'd0) begin
            n_bad++; $display("FAIL reset_cycle: got %h want 0", r);
        end
        do_op(0, 0, 1, MB + 9'h4, 0, 3'b010, r);
        n_total++;
        if (r !== 32'd0) begin
            n_bad++; $display("FAIL reset_stores: got %h want 0", r);
        end
        do_op(0, 0, 0, 9'h010, 32'hFFFF_FFFF, 3'b010, r);
        n_total++;
        if (r !== 32'd0) begin
            n_bad++; $display("FAIL no_request: got %h want 0", r);
        end
    endtask

    task automatic test_word_byte();
        logic [31:0] r;
        do_op(0, 1, 0, 9'h010, 32'hDEADBEEF, 3'b010, r);
        do_op(0, 0, 1, 9'h010, 0, 3'b010, r);
        n_total++;
        if (r !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL lw: got %h want deadbeef", r);
        end
        do_op(0, 0, 1, 9'h013, 0, 3'b000, r);
        n_total++;
        if (r !== 32'hFFFFFFDE) begin
            n_bad++; $display("FAIL lb: got %h want ffffffde", r);
        end
        do_op(0, 0, 1, 9'h013, 0, 3'b100, r);
        n_total++;
        if (r !== 32'h000000DE) begin
            n_bad++; $display("FAIL lbu: got %h want 000000de", r);
        end
        do_op(0, 0, 1, 9'h012, 0, 3'b001, r);
        n_total++;
        if (r !== 32'hFFFFDEAD) begin
            n_bad++; $display("FAIL lh: got %h want ffffdead", r);
        end
    endtask

    task automatic test_half_merge();
        logic [31:0] r;
        do_op(0, 1, 0, 9'h022, 32'h0000_1234, 3'b001, r);
        do_op(0, 0, 1, 9'h020, 0, 3'b010, r);
        n_total++;
        if (r !== 32'h12340000) begin
            n_bad++; $display("FAIL sh_merge: got %h want 12340000", r);
        end
        do_op(0, 0, 1, MB + 9'h4, 0, 3'b010, r);
        n_total++;
        if (r !== 32'd2) begin
            n_bad++; $display("FAIL stores_cnt: got %h want 2", r);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] r;
        do_op(0, 0, 1, 9'h011, 0, 3'b010, r);
        n_total++;
        if (r !== 32'd0) begin
            n_bad++; $display("FAIL misalign_data: got %h want 0", r);
        end
        n_total++;
        if (err !== 1'b1) begin
            n_bad++; $display("FAIL misalign_err: got %b want 1", err);
        end
        do_op(0, 0, 1, 9'h010, 0, 3'b010, r);
        n_total++;
        if (r !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL misalign_ram: got %h want deadbeef", r);
        end
        do_op(0, 0, 1, MB + 9'hC, 0, 3'b010, r);
        n_total++;
        if (r !== 32'h1) begin
            n_bad++; $display("FAIL status_err: got %h want 1", r);
        end
    endtask

    task automatic test_mmio();
        logic [31:0] r;
        logic [31:0] e;
        apply_reset();
        do_op(0, 1, 0, MB + 9'h8, 32'h0BAD, 3'b001, r);
        n_total++;
        if (err !== 1'b1 || done !== 1'b0 || tohost !== 32'd0) begin
            n_bad++;
            $display("FAIL sh_tohost: got err=%b done=%b tohost=%h want 1 0 0",
                     err, done, tohost);
        end
        do_op(0, 1, 0, MB + 9'h0, 32'd5, 3'b010, r);
        e = m_read(0, 1, MB + 9'h0, 3'b010);
        do_op(0, 0, 1, MB + 9'h0, 0, 3'b010, r);
        n_total++;
        if (r !== e || r === 32'd5) begin
            n_bad++; $display("FAIL cycle_ro: got %h want %h", r, e);
        end
        do_op(0, 1, 0, MB + 9'h8, 32'h600D, 3'b010, r);
        n_total++;
        if (tohost !== 32'h600D || done !== 1'b1) begin
            n_bad++;
            $display("FAIL tohost_wr: got %h done=%b want 600d 1", tohost, done);
        end
        do_op(0, 0, 1, MB + 9'hC, 0, 3'b010, r);
        n_total++;
        if (r !== 32'h3) begin
            n_bad++; $display("FAIL status_both: got %h want 3", r);
        end
        do_op(0, 0, 1, 9'h010, 0, 3'b010, r);
        n_total++;
        if (r !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL after_done: got %h want deadbeef", r);
        end
    endtask

    task automatic test_cycle();
        logic [31:0] r;
        apply_reset();
        idle(10);
        do_op(0, 0, 1, MB + 9'h0, 0, 3'b010, r);
        n_total++;
        if (r !== 32'd10) begin
            n_bad++; $display("FAIL cycle_10: got %0d want 10", r);
        end
    endtask

    task automatic test_reset_store();
        logic [31:0] r;
        do_op(0, 1, 0, MB + 9'h8, 32'h77, 3'b010, r);
        do_op(1, 1, 0, 9'h030, 32'hCAFEF00D, 3'b010, r);
        for (int i = 0; i < 4; i++) begin
            do_op(0, 0, 1, MB + 9'(4 * i), 0, 3'b010, r);
            n_total++;
            if (r !== 32'd0) begin
                n_bad++; $display("FAIL rst_mmio%0d: got %h want 0", i, r);
            end
        end
        do_op(0, 0, 1, 9'h030, 0, 3'b010, r);
        n_total++;
        if (r !== 32'd0) begin
            n_bad++; $display("FAIL rst_store: got %h want 0", r);
        end
        do_op(0, 0, 1, 9'h010, 0, 3'b010, r);
        n_total++;
        if (r !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL rst_ram_keep: got %h want deadbeef", r);
        end
        n_total++;
        if (err !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_flags: got err=%b done=%b want 0 0", err, done);
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] e;
        logic        w;
        logic        rr;
        logic [8:0]  a;
        logic [2:0]  f;
        logic [2:0]  lf [5];
        int          sel;
        int          sz;
        lf[0] = 3'b000; lf[1] = 3'b001; lf[2] = 3'b010;
        lf[3] = 3'b100; lf[4] = 3'b101;
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 19));
            w  = (sel == 0) || (sel >= 2 && sel <= 9);
            rr = (sel == 0) || (sel >= 10);
            if ($urandom_range(0, 15) == 0)
                f = 3'($urandom);
            else if (w && !rr)
                f = lf[$urandom_range(0, 2)];
            else
                f = lf[$urandom_range(0, 4)];
            if ($urandom_range(0, 7) == 0)
                a = MB + 9'($urandom_range(0, 15));
            else
                a = 9'($urandom_range(0, 127));
            sz = m_size(f);
            if ($urandom_range(0, 7) != 0)
                a = 9'(int'(a) - (int'(a) % sz));
            e = m_read(w, rr, a, f);
            do_op(0, w, rr, a, $urandom, f, r);
            n_total++;
            if (r !== e) begin
                n_bad++;
                $display("FAIL rnd_rdata[%0d] a=%h f=%0d: got %h want %h",
                         i, a, f, r, e);
            end
            n_total++;
            if (err !== m_err || done !== m_done || tohost !== m_tohost) begin
                n_bad++;
                $display("FAIL rnd_state[%0d]: got %b %b %h want %b %b %h",
                         i, err, done, tohost, m_err, m_done, m_tohost);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) m_ram[i] = 8'h00;
        reset       = 1'b1;
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        bus.addr    = '0;
        bus.wr_data = '0;
        bus.func3   = '0;
        test_reset();
        test_word_byte();
        test_half_merge();
        test_misalign();
        test_mmio();
        test_cycle();
        test_reset_store();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
